// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: CPU memory stage has priority, an external
// valid/ready requester is forced in after MAX_CPU_BURST consecutive denials.
module dmem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_valid_i,
  output logic              ext_ready_o,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_rvalid_o,
  input  logic              ext_rready_i,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  output logic              grant_ext_o
);

  localparam int SW = (MAX_CPU_BURST == 0) ? 1 : $clog2(MAX_CPU_BURST + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_CPU_BURST);

  logic [SW-1:0]     streak_q, streak_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic rsp_free, forced, ext_ready, accept;

  // With a zero burst limit the external side always has priority.
  if (MAX_CPU_BURST == 0) begin : g_strict
    assign forced = 1'b1;
  end else begin : g_burst
    assign forced = (streak_q >= MAX_S);
  end

  assign rsp_free  = !rvalid_q || ext_rready_i;
  assign ext_ready = rsp_free && (!cpu_req_i || forced);
  assign accept    = ext_valid_i && ext_ready;

  assign ext_ready_o  = ext_ready;
  assign grant_ext_o  = accept;
  assign cpu_stall_o  = cpu_req_i && accept;
  assign cpu_rdata_o  = mem_rd_i;
  assign ext_rvalid_o = rvalid_q;
  assign ext_rdata_o  = rdata_q;

  always_comb begin
    if (accept) begin
      mem_we_o   = ext_we_i;
      mem_addr_o = ext_addr_i;
      mem_wd_o   = ext_wdata_i;
    end else begin
      mem_we_o   = cpu_req_i && cpu_we_i;
      mem_addr_o = cpu_addr_i;
      mem_wd_o   = cpu_wdata_i;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (accept || !ext_valid_i) begin
      streak_d = '0;
    end else if (cpu_req_i && (streak_q != MAX_S)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // A new read accept reloads the response even when the old one is consumed.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (accept && !ext_we_i) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rd_i;
    end else if (rvalid_q && ext_rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      streak_q <= streak_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with burst limit 4, one with
// burst limit 0 sharing the same stimulus.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, ext_valid = 0, ext_we = 0, ext_rready = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0, mem_rd = 0;

  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wd;
  logic        cpu_stall, ext_ready, ext_rvalid, mem_we, grant_ext;
  logic [31:0] z_cpu_rdata, z_ext_rdata, z_mem_addr, z_mem_wd;
  logic        z_cpu_stall, z_ext_ready, z_ext_rvalid, z_mem_we, z_grant_ext;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_CPU_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ext_valid_i(ext_valid), .ext_ready_o(ext_ready), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rvalid_o(ext_rvalid), .ext_rready_i(ext_rready), .ext_rdata_o(ext_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
    .grant_ext_o(grant_ext)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_CPU_BURST(0)) dut_z (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(z_cpu_rdata), .cpu_stall_o(z_cpu_stall),
    .ext_valid_i(ext_valid), .ext_ready_o(z_ext_ready), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_rvalid_o(z_ext_rvalid), .ext_rready_i(ext_rready), .ext_rdata_o(z_ext_rdata),
    .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr), .mem_wd_o(z_mem_wd), .mem_rd_i(mem_rd),
    .grant_ext_o(z_grant_ext)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
    check("rst_rdata", ext_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1: CPU-only store
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5; mem_rd = 32'h55;
    #1;
    check("t1_mem_we", {31'b0, mem_we}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_wd", mem_wd, 32'hA5);
    check("t1_stall", {31'b0, cpu_stall}, 32'd0);
    check("t1_ext_ready", {31'b0, ext_ready}, 32'd0);
    check("t1_cpu_rdata", cpu_rdata, 32'h55);
    step();
    $display("txn 1: cpu store addr=0x10 data=0xA5");

    // 2: external read with CPU idle
    cpu_req = 0; cpu_we = 0; ext_valid = 1; ext_we = 0; ext_addr = 32'h20;
    mem_rd = 32'h1234; ext_rready = 0;
    #1;
    check("t2_ready", {31'b0, ext_ready}, 32'd1);
    check("t2_grant", {31'b0, grant_ext}, 32'd1);
    check("t2_mem_addr", mem_addr, 32'h20);
    check("t2_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    ext_valid = 0; mem_rd = 32'h0;
    check("t2_rvalid", {31'b0, ext_rvalid}, 32'd1);
    check("t2_rdata", ext_rdata, 32'h1234);
    ext_rready = 1;
    step();
    check("t2_rvalid_clr", {31'b0, ext_rvalid}, 32'd0);
    check("t2_rdata_hold", ext_rdata, 32'h1234);
    $display("txn 2: ext read addr=0x20 data=0x%0h", ext_rdata);

    // 3: contention with burst limit 4 (ext writes, no responses)
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; ext_valid = 1; ext_we = 1;
    ext_addr = 32'h44; ext_wdata = 32'hCAFE;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("t3_grant_c%0d", c), {31'b0, grant_ext}, (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_stall_c%0d", c), {31'b0, cpu_stall}, (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_addr_c%0d", c), mem_addr, (c == 4) ? 32'h44 : 32'h40);
      $display("txn 3: cycle %0d grant_ext=%0b cpu_stall=%0b", c, grant_ext, cpu_stall);
      step();
    end
    check("t3_rvalid", {31'b0, ext_rvalid}, 32'd0);

    // 4: backpressure then consume+reload in one cycle
    cpu_req = 0; ext_valid = 1; ext_we = 0; ext_addr = 32'h30; mem_rd = 32'hAAAA; ext_rready = 0;
    #1;
    check("t4_ready0", {31'b0, ext_ready}, 32'd1);
    step();
    check("t4_rvalid", {31'b0, ext_rvalid}, 32'd1);
    check("t4_rdata", ext_rdata, 32'hAAAA);
    ext_addr = 32'h34; mem_rd = 32'hBBBB;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("t4_bp_ready_c%0d", c), {31'b0, ext_ready}, 32'd0);
      check($sformatf("t4_bp_grant_c%0d", c), {31'b0, grant_ext}, 32'd0);
      step();
      check($sformatf("t4_bp_rdata_c%0d", c), ext_rdata, 32'hAAAA);
      check($sformatf("t4_bp_rvalid_c%0d", c), {31'b0, ext_rvalid}, 32'd1);
    end
    ext_rready = 1;
    #1;
    check("t4_reload_ready", {31'b0, ext_ready}, 32'd1);
    check("t4_reload_grant", {31'b0, grant_ext}, 32'd1);
    step();
    check("t4_reload_rvalid", {31'b0, ext_rvalid}, 32'd1);
    check("t4_reload_rdata", ext_rdata, 32'hBBBB);
    ext_valid = 0;
    step();
    check("t4_drain_rvalid", {31'b0, ext_rvalid}, 32'd0);
    $display("txn 4: backpressure released, rdata=0x%0h", ext_rdata);

    // 5: burst limit 0 -> ext wins every cycle
    cpu_req = 1; ext_valid = 1; ext_we = 1; ext_rready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("t5_grant_c%0d", c), {31'b0, z_grant_ext}, 32'd1);
      check($sformatf("t5_stall_c%0d", c), {31'b0, z_cpu_stall}, 32'd1);
      $display("txn 5: cycle %0d grant_ext=%0b cpu_stall=%0b", c, z_grant_ext, z_cpu_stall);
      step();
    end

    // 6: reset while a response is pending and streak=3
    cpu_req = 0; ext_valid = 0;
    step();
    ext_valid = 1; ext_we = 0; ext_rready = 0; mem_rd = 32'h77;
    step();
    check("t6_rvalid_pre", {31'b0, ext_rvalid}, 32'd1);
    cpu_req = 1;
    for (int c = 0; c < 3; c++) step();
    check("t6_streak_pre", 32'(dut.streak_q), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rvalid_rst", {31'b0, ext_rvalid}, 32'd0);
    check("t6_rdata_rst", ext_rdata, 32'd0);
    check("t6_streak_rst", 32'(dut.streak_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ext_rready = 1; ext_we = 1;
    #1;
    check("t6_post_grant", {31'b0, grant_ext}, 32'd0);
    check("t6_post_stall", {31'b0, cpu_stall}, 32'd0);
    $display("txn 6: reset mid-transaction, rvalid=%0b", ext_rvalid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
